adc_frame_pingpong: RTL and testbench
=====================================

// Module: adc_frame_pingpong
// PURPOSE
//  Ping-pong frame buffer downstream of the AD9280 sampler. Captures whole
//  DEPTH-sample frames from the sampler's write port into two RAM banks and
//  replays each completed frame as an AXI-Stream-style burst to the FFT/display
//  path. Writing one bank while reading the other decouples sampling from a
//  back-pressuring consumer. Single clock domain (adc_clk).
// PARAMETERS
//  DATA_W   8     sample width
//  DEPTH    1024  samples per frame (power of two)
//  ADDR_W   10    log2(DEPTH); lower ADDR_W bits of wr_addr are used, the rest ignored
// PORTS
//  adc_clk        in   1       clock
//  rst_n          in   1       asynchronous reset, active low
//  wr_en          in   1       sample write strobe (sampler adc_buf_wr)
//  wr_addr        in   12      sample index within frame (sampler adc_buf_addr)
//  wr_data        in   DATA_W  sample (sampler adc_buf_data)
//  wr_last        in   1       final sample of frame; qualified by wr_en
//  m_axis_tdata   out  DATA_W  replayed sample
//  m_axis_tvalid  out  1       tdata/tlast valid
//  m_axis_tready  in   1       consumer accepts on tvalid&tready
//  m_axis_tlast   out  1       high with sample DEPTH-1 of a burst
//  bank_full      out  2       per-bank "holds complete unread frame"
//  drop_cnt       out  16      frames discarded (no free bank), saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; wr FSM=W_IDLE, wr_bank=0, rd FSM=R_IDLE,
//   rd_bank=0, output pipeline emptied. Reset mid-burst abandons the frame; RAM
//   contents are don't-care.
//  Write FSM (decisions use registered bank_full):
//   W_IDLE : wr_en & wr_addr[ADDR_W-1:0]==0 -> if !bank_full[wr_bank] write sample,
//            go W_STORE; else go W_SKIP. wr_en with nonzero addr ignored (resync).
//   W_STORE: each wr_en writes mem[wr_bank][wr_addr]. wr_en&wr_last -> sample
//            written, bank_full[wr_bank]<=1, wr_bank toggles, go W_IDLE.
//   W_SKIP : writes discarded; wr_en&wr_last -> drop_cnt+1 (saturating), W_IDLE.
//   Frame start and last in same cycle (wr_last at addr 0) = 1-sample frame, legal.
//  Read FSM:
//   R_IDLE : bank_full[rd_bank]=1 -> start fetching address 0, go R_STREAM.
//   R_STREAM: RAM read latency 1; prefetch/skid so that with tready held high
//            tvalid stays high DEPTH consecutive cycles (1 sample/clk).
//            First tvalid exactly 2 cycles after bank_full[rd_bank] rises.
//            Handshake of sample with tlast=1: bank_full[rd_bank]<=0, rd_bank
//            toggles, go R_IDLE on same edge.
//  AXI rules: tvalid never drops without handshake; tdata/tlast held stable
//   while tvalid & !tready; tvalid does not depend combinationally on tready.
//  Samples emitted in address order 0..DEPTH-1 of the bank, oldest full bank first.
//  Simultaneous events: write marking bank A full while read clears bank B on
//   same edge: both take effect. Frame start sampled in the same cycle the read
//   side clears wr_bank: sees old value (full) -> W_SKIP.
//  Banks alternate strictly: wr_bank and rd_bank only toggle on frame completion.
// TESTING
//  1 Write frame 0..1023 data=addr[7:0], tready=1 -> tvalid 2 clk after bank_full[0]
//    rises, 1024 beats data 0..255 repeating, tlast on beat 1023, bank_full=00 after.
//  2 tready toggling 1/0 every cycle during burst -> no lost/duplicated samples,
//    tdata stable in stalled cycles, 1024 handshakes total.
//  3 tready=0, write 3 frames -> frames 1,2 fill banks 0,1; frame 3 dropped,
//    drop_cnt=1, bank_full=11; then tready=1 -> frame 1 then frame 2 replayed.
//  4 Write frame starting at wr_addr=5 (no addr 0) -> ignored, bank_full stays 00;
//    next frame from addr 0 captured normally.
//  5 Assert rst_n=0 at beat 500 of burst -> all outputs 0 immediately; after release
//    a new frame replays cleanly from sample 0.
//  6 Force drop_cnt to 16'hFFFE, drop 3 frames -> drop_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/adc_frame_pingpong.sv
// Ping-pong frame buffer: captures whole DEPTH-sample frames from the ADC
// sampler into two alternating RAM banks and replays each completed frame
// as an AXI-Stream burst with full back-pressure support.
module adc_frame_pingpong #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [11:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [1:0]        bank_full,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_SKIP} wstate_t;
  typedef enum logic {R_IDLE, R_STREAM} rstate_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Both banks share one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  logic [ADDR_W-1:0] waddr;
  logic              unused_addr_bits;

  wstate_t           wstate, wstate_n;
  logic              wr_bank, wr_bank_n;
  logic              mem_we;
  logic [1:0]        set_full;
  logic              drop_inc;

  rstate_t           rstate, rstate_n;
  logic              rd_bank, rd_bank_n;
  logic [1:0]        clr_full;

  logic              rd_en_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic [ADDR_W-1:0] fetch_addr_p0;
  logic              fetch_done_p0;

  logic              vld_p1;
  logic              last_p1;
  logic [DATA_W-1:0] data_p1;

  logic              out_ready;
  logic              p1_free;
  logic              handshake;

  // Only the in-frame index bits address the RAM; the upper bits are ignored.
  assign waddr            = wr_addr[ADDR_W-1:0];
  assign unused_addr_bits = ^wr_addr;

  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign p1_free   = !vld_p1 || out_ready;
  assign handshake = m_axis_tvalid && m_axis_tready;

  // Write FSM: frame sync on address 0, capture into a free bank or skip the frame.
  always_comb begin
    wstate_n  = wstate;
    wr_bank_n = wr_bank;
    mem_we    = 1'b0;
    set_full  = 2'b00;
    drop_inc  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (wr_en && waddr == '0) begin
          if (!bank_full[wr_bank]) begin
            mem_we = 1'b1;
            if (wr_last) begin
              set_full[wr_bank] = 1'b1;
              wr_bank_n         = ~wr_bank;
            end else begin
              wstate_n = W_STORE;
            end
          end else if (wr_last) begin
            drop_inc = 1'b1;
          end else begin
            wstate_n = W_SKIP;
          end
        end
      end
      W_STORE: begin
        if (wr_en) begin
          mem_we = 1'b1;
          if (wr_last) begin
            set_full[wr_bank] = 1'b1;
            wr_bank_n         = ~wr_bank;
            wstate_n          = W_IDLE;
          end
        end
      end
      W_SKIP: begin
        if (wr_en && wr_last) begin
          drop_inc = 1'b1;
          wstate_n = W_IDLE;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // Read FSM: start a burst when the current read bank is full, finish on tlast handshake.
  always_comb begin
    rstate_n   = rstate;
    rd_bank_n  = rd_bank;
    clr_full   = 2'b00;
    rd_en_p0   = 1'b0;
    rd_addr_p0 = fetch_addr_p0;
    case (rstate)
      R_IDLE: begin
        if (bank_full[rd_bank]) begin
          rd_en_p0   = 1'b1;
          rd_addr_p0 = '0;
          rstate_n   = R_STREAM;
        end
      end
      R_STREAM: begin
        rd_en_p0 = !fetch_done_p0 && p1_free;
        if (handshake && m_axis_tlast) begin
          clr_full[rd_bank] = 1'b1;
          rd_bank_n         = ~rd_bank;
          rstate_n          = R_IDLE;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // Control state: FSMs, bank pointers, full flags and the drop counter.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      wr_bank   <= 1'b0;
      rstate    <= R_IDLE;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      drop_cnt  <= 16'h0000;
    end else begin
      wstate    <= wstate_n;
      wr_bank   <= wr_bank_n;
      rstate    <= rstate_n;
      rd_bank   <= rd_bank_n;
      // Set and clear always target different banks, so both can land on one edge.
      bank_full <= (bank_full & ~clr_full) | set_full;
      if (drop_inc && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Stage p0 -> p1: fetch address counter and RAM-output valid/last tracking.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_p0 <= '0;
      fetch_done_p0 <= 1'b0;
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
    end else begin
      if (rd_en_p0) begin
        fetch_addr_p0 <= rd_addr_p0 + ADDR_W'(1);
        fetch_done_p0 <= (rd_addr_p0 == LAST_ADDR);
        vld_p1        <= 1'b1;
        last_p1       <= (rd_addr_p0 == LAST_ADDR);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p1 -> p2: output register; holds steady while the consumer stalls.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (out_ready) begin
      m_axis_tvalid <= vld_p1;
      m_axis_tlast  <= vld_p1 && last_p1;
      if (vld_p1)
        m_axis_tdata <= data_p1;
    end
  end

  // RAM write port.
  always_ff @(posedge adc_clk) begin
    if (mem_we)
      mem[{wr_bank, waddr}] <= wr_data;
  end

  // RAM read port, registered (one cycle latency), enabled only when p1 can advance.
  always_ff @(posedge adc_clk) begin
    if (rd_en_p0)
      data_p1 <= mem[{rd_bank, rd_addr_p0}];
  end

endmodule

// File: tb/tb_adc_frame_pingpong.sv
// Scoreboard bench for adc_frame_pingpong: frames are driven with random data,
// gaps and back-pressure; a frame-level model predicts acceptance, drops and
// the replayed beat stream, which a separate monitor compares.
module tb_adc_frame_pingpong;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [11:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready = 1'b0;
  logic              tlast;
  logic [1:0]        bank_full;
  logic [15:0]       drop_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: frames held (written, not fully replayed), expected beats, drops.
  logic [DATA_W:0] exp_q [$];
  int held     = 0;
  int exp_drop = 0;
  int hs_cnt   = 0;
  int rdy_mode = 1;   // 0: never ready, 1: always, 2: toggle, 3: random

  logic            prev_stall = 1'b0;
  logic [DATA_W:0] prev_beat  = '0;

  adc_frame_pingpong #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .adc_clk       (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .bank_full     (bank_full),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready pattern, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      2:       tready = ~tready;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: checks AXI stability while stalled and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_beat", {tlast, tdata}, prev_beat);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {tlast, tdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {tlast, tdata}, e);
          hs_cnt++;
          if (e[DATA_W]) held--;
        end
      end
      prev_stall = tvalid && !tready;
      prev_beat  = {tlast, tdata};
    end
  end

  // Drives samples start..DEPTH-1; only a frame that starts at index 0 while a
  // bank is free is captured, and it becomes visible when its last sample lands.
  task automatic send_frame(input int start, input bit rnd_data, input bit gaps, input bit rnd_hi);
    logic [DATA_W-1:0] fr [DEPTH];
    logic [DATA_W-1:0] d;
    bit acc;
    acc = 1'b0;
    for (int a = start; a < DEPTH; a++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          wr_en = 1'b0;
          wr_last = 1'b0;
          @(posedge clk); #1;
        end
      end
      if (a == start) acc = (start == 0) && (held < 2);
      d = rnd_data ? DATA_W'($urandom) : DATA_W'(a);
      fr[a]   = d;
      wr_en   = 1'b1;
      wr_addr = 12'(a);
      if (rnd_hi) wr_addr[11:ADDR_W] = (12-ADDR_W)'($urandom);
      wr_data = d;
      wr_last = (a == DEPTH - 1);
      if (a == DEPTH - 1 && start == 0) begin
        if (acc) begin
          for (int k = 0; k < DEPTH; k++) exp_q.push_back({(k == DEPTH - 1), fr[k]});
          held++;
        end else if (exp_drop < 65535) begin
          exp_drop++;
        end
      end
      @(posedge clk); #1;
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  // One-sample frame; used only while both banks are occupied, so it is a drop.
  task automatic send_one_dropped();
    wr_en   = 1'b1;
    wr_addr = 12'h000;
    wr_data = DATA_W'($urandom);
    wr_last = 1'b1;
    if (exp_drop < 65535) exp_drop++;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 8000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drain_done"}, (exp_q.size() == 0), 1);
    check({name, "_bank_full_empty"}, bank_full, 2'b00);
    check({name, "_tvalid_idle"}, tvalid, 0);
    check({name, "_drop_cnt"}, drop_cnt, exp_drop[15:0]);
  endtask

  initial begin
    int base;
    int i;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_last = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame with ramp data, ready held high: latency and full burst.
    rdy_mode = 1;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    check("t1_bank_full_set", bank_full, 2'b01);
    check("t1_tvalid_c0", tvalid, 0);
    @(posedge clk); #1;
    check("t1_tvalid_c1", tvalid, 0);
    @(posedge clk); #1;
    check("t1_tvalid_c2", tvalid, 1);
    check("t1_first_data", tdata, 0);
    wait_drain("t1");

    // Alternating ready: every sample exactly once.
    rdy_mode = 2;
    base = hs_cnt;
    send_frame(0, 1'b1, 1'b0, 1'b0);
    wait_drain("t2");
    check("t2_handshakes", hs_cnt - base, DEPTH);

    // Consumer blocked: two frames fill the banks, the third is dropped.
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send_frame(0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 1'b1, 1'b0, 1'b0);
    check("t3_bank_full", bank_full, 2'b11);
    check("t3_drop_cnt", drop_cnt, 1);
    rdy_mode = 1;
    wait_drain("t3");

    // Frame without index 0 is ignored; the next aligned frame is captured.
    send_frame(5, 1'b1, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("t4_ignored_bank_full", bank_full, 2'b00);
    check("t4_ignored_tvalid", tvalid, 0);
    send_frame(0, 1'b1, 1'b0, 1'b1);
    wait_drain("t4");

    // Reset in the middle of a burst, then a clean frame afterwards.
    base = hs_cnt;
    send_frame(0, 1'b0, 1'b0, 1'b0);
    for (i = 0; i < 4000 && (hs_cnt - base) < 500; i++) @(posedge clk);
    #1;
    check("t5_reached_beat_500", ((hs_cnt - base) >= 500), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", tvalid, 0);
    check("t5_rst_tdata", tdata, 0);
    check("t5_rst_tlast", tlast, 0);
    check("t5_rst_bank_full", bank_full, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    held     = 0;
    exp_drop = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 1'b1, 1'b1, 1'b0);
    wait_drain("t5");

    // Drop counter saturation near the top of its range.
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send_frame(0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 1'b1, 1'b0, 1'b0);
    check("t6_bank_full", bank_full, 2'b11);
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    exp_drop = 32'hFFFE;
    repeat (3) send_one_dropped();
    check("t6_drop_saturated", drop_cnt, 16'hFFFF);
    rdy_mode = 1;
    wait_drain("t6");

    // Randomised traffic: random data, write gaps, random ready, random idle time.
    rdy_mode = 3;
    for (int f = 0; f < 5; f++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      send_frame(0, 1'b1, 1'b1, 1'b1);
    end
    wait_drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
